// File: rtl/alu_md.sv
// EX-stage ALU: single-cycle combinational path plus a multi-cycle multiply/divide unit
// with HI/LO result registers and a Start/Busy handshake.
module alu_md #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       ALUOp,
   output logic [WIDTH-1:0] C,
   input  logic [2:0]       MDOp,
   input  logic             Start,
   output logic             Busy,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO
);

   localparam int SH_W  = $clog2(WIDTH);
   localparam int MAX_N = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W = $clog2(MAX_N + 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [2:0] {
      MD_NOP, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO, MD_RSVD
   } md_op_e;

   typedef enum logic {S_IDLE, S_RUN} state_e;

   // Combinational ALU path, independent of the MD unit.
   logic [SH_W-1:0] sh;
   assign sh = B[SH_W-1:0];

   always_comb begin
      C = '0;
      unique case (ALUOp)
         3'd0: C = A + B;
         3'd1: C = A - B;
         3'd2: C = A & B;
         3'd3: C = A | B;
         3'd4: C = A >> sh;
         3'd5: C = $signed(A) >>> sh;
         3'd6: C = A << sh;
         3'd7: C = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
         default: C = '0;
      endcase
   end

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   md_op_e           op_q,    op_d;
   logic [WIDTH-1:0] a_q,     a_d;
   logic [WIDTH-1:0] b_q,     b_d;
   logic [WIDTH-1:0] hi_q,    hi_d;
   logic [WIDTH-1:0] lo_q,    lo_d;

   // Result computed from the latched operands; only committed when the counter expires.
   logic [2*WIDTH-1:0] mul_a, mul_b, prod;
   logic               a_neg, b_neg, div_zero;
   logic [WIDTH-1:0]   a_mag, b_mag, quo_mag, rem_mag, quo, rem;

   always_comb begin
      mul_a = (op_q == MD_MULT) ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
      mul_b = (op_q == MD_MULT) ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
      prod  = mul_a * mul_b;

      // Sign-magnitude divide: avoids the most-negative / -1 overflow of a native signed divide.
      a_neg    = (op_q == MD_DIV) && a_q[WIDTH-1];
      b_neg    = (op_q == MD_DIV) && b_q[WIDTH-1];
      a_mag    = a_neg ? -a_q : a_q;
      b_mag    = b_neg ? -b_q : b_q;
      div_zero = (b_q == '0);
      quo_mag  = div_zero ? '0 : a_mag / b_mag;
      rem_mag  = div_zero ? '0 : a_mag % b_mag;
      quo      = (a_neg ^ b_neg) ? -quo_mag : quo_mag;
      rem      = a_neg ? -rem_mag : rem_mag;
   end

   always_comb begin
      // NOTE: every next-state signal gets a hold default first so no path infers a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      unique case (state_q)
         S_IDLE: begin
            if (Start) begin
               unique case (md_op_e'(MDOp))
                  MD_MULT, MD_MULTU: begin
                     state_d = S_RUN;
                     cnt_d   = CNT_W'(MULT_CYCLES);
                     op_d    = md_op_e'(MDOp);
                     a_d     = A;
                     b_d     = B;
                  end
                  MD_DIV, MD_DIVU: begin
                     state_d = S_RUN;
                     cnt_d   = CNT_W'(DIV_CYCLES);
                     op_d    = md_op_e'(MDOp);
                     a_d     = A;
                     b_d     = B;
                  end
                  MD_MTHI: hi_d = A;
                  MD_MTLO: lo_d = A;
                  default: ;
               endcase
            end
         end
         S_RUN: begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               state_d = S_IDLE;
               if (op_q == MD_MULT || op_q == MD_MULTU) begin
                  hi_d = prod[2*WIDTH-1:WIDTH];
                  lo_d = prod[WIDTH-1:0];
               end else if (!div_zero) begin
                  hi_d = rem;
                  lo_d = quo;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= MD_NOP;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign Busy = (state_q == S_RUN);
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: tb/tb_alu_md.sv
// Directed self-checking bench for alu_md: a 32-bit default instance and a
// 16-bit instance with a one-cycle multiply.
module tb_alu_md;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] a, b, c, hi, lo;
   logic [2:0]  aluop, mdop;
   logic        start, busy;

   logic [15:0] a2, b2, c2, hi2, lo2;
   logic [2:0]  aluop2, mdop2;
   logic        start2, busy2;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_md dut (
      .clk(clk), .reset(reset), .A(a), .B(b), .ALUOp(aluop), .C(c),
      .MDOp(mdop), .Start(start), .Busy(busy), .HI(hi), .LO(lo)
   );

   alu_md #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut16 (
      .clk(clk), .reset(reset), .A(a2), .B(b2), .ALUOp(aluop2), .C(c2),
      .MDOp(mdop2), .Start(start2), .Busy(busy2), .HI(hi2), .LO(lo2)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic alu(input string tag, input logic [2:0] op, input logic [31:0] x,
                      input logic [31:0] y, input logic [31:0] exp);
      a = x; b = y; aluop = op;
      #1 check(tag, c, exp);
   endtask

   // Called just after a negedge; returns at the first negedge after the Start edge.
   task automatic start_md(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
      a = x; b = y; mdop = op; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Counts the Busy cycles still to come and checks HI/LO hold until the op completes.
   task automatic wait_done(input string tag, input int n, input logic [31:0] exp_hi,
                            input logic [31:0] exp_lo);
      int          cnt = 0;
      logic [63:0] held;
      logic [63:0] last;
      held = {hi, lo};
      last = held;
      while (busy === 1'b1 && cnt < 100) begin
         last = {hi, lo};
         cnt++;
         @(negedge clk);
      end
      check({tag, "_cycles"}, 64'(cnt), 64'(n));
      check({tag, "_hold"}, last, held);
      check({tag, "_hilo"}, {hi, lo}, {exp_hi, exp_lo});
   endtask

   task automatic start_md2(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y);
      a2 = x; b2 = y; mdop2 = op; start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
   endtask

   task automatic wait_done2(input string tag, input int n, input logic [15:0] exp_hi,
                             input logic [15:0] exp_lo);
      int cnt = 0;
      while (busy2 === 1'b1 && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
      check({tag, "_cycles"}, 64'(cnt), 64'(n));
      check({tag, "_hilo"}, {hi2, lo2}, {exp_hi, exp_lo});
   endtask

   initial begin
      reset = 1'b1; start = 1'b1; mdop = 3'd1; a = 32'd3; b = 32'd5; aluop = 3'd0;
      start2 = 1'b1; mdop2 = 3'd1; a2 = 16'd3; b2 = 16'd5; aluop2 = 3'd0;
      repeat (2) @(negedge clk);
      reset = 1'b0; start = 1'b0; start2 = 1'b0;
      @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_hilo", {hi, lo}, 64'd0);
      check("rst16", {15'd0, busy2, hi2, lo2}, 64'd0);

      // Combinational sweep
      alu("add",  3'd0, 32'd7, 32'd16, 32'd23);
      alu("sub",  3'd1, 32'd7, 32'd16, 32'hFFFF_FFF7);
      alu("and",  3'd2, 32'd7, 32'd16, 32'd0);
      alu("or",   3'd3, 32'd7, 32'd16, 32'd23);
      alu("srl",  3'd4, 32'd7, 32'd16, 32'd0);
      alu("sra",  3'd5, 32'd7, 32'd16, 32'd0);
      alu("sll",  3'd6, 32'd7, 32'd16, 32'h0007_0000);
      alu("slt",  3'd7, 32'd7, 32'd16, 32'd1);
      alu("srl_neg", 3'd4, 32'h8000_0000, 32'd1, 32'h4000_0000);
      alu("sra_neg", 3'd5, 32'h8000_0000, 32'd1, 32'hC000_0000);
      alu("slt_neg", 3'd7, 32'h8000_0000, 32'd1, 32'd1);
      alu("slt_ge",  3'd7, 32'd5, 32'hFFFF_FFFF, 32'd0);
      alu("add_wrap", 3'd0, 32'hFFFF_FFFF, 32'd2, 32'd1);
      @(negedge clk);

      // Multiply / divide, each issued on the first cycle Busy reads 0
      start_md(3'd1, 32'hFFFF_FFFD, 32'd5);
      alu("c_during_busy", 3'd0, 32'd1, 32'd2, 32'd3);
      wait_done("mult", 5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      start_md(3'd2, 32'hFFFF_FFFF, 32'd2);
      wait_done("multu", 5, 32'd1, 32'hFFFF_FFFE);
      start_md(3'd3, 32'hFFFF_FFF9, 32'd2);
      wait_done("div", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      start_md(3'd4, 32'd7, 32'd0);
      wait_done("divu_zero", 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      start_md(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done("div_ovf", 10, 32'd0, 32'h8000_0000);
      start_md(3'd4, 32'd100, 32'd7);
      wait_done("divu", 10, 32'd2, 32'd14);

      // MTLO while busy must be ignored; the multiply still completes normally
      start_md(3'd1, 32'd6, 32'd7);
      mdop = 3'd6; a = 32'h55; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("mtlo_busy", 4, 32'd0, 32'd42);

      // MTHI in IDLE
      start_md(3'd5, 32'h1234, 32'd0);
      check("mthi_hi", 64'(hi), 64'h1234);
      check("mthi_busy", 64'(busy), 64'd0);
      start_md(3'd6, 32'hBEEF, 32'd0);
      check("mtlo_lo", {hi, lo}, {32'h1234, 32'hBEEF});

      // Reset three cycles into a divide
      start_md(3'd4, 32'd100, 32'd3);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_hilo", {hi, lo}, 64'd0);
      repeat (12) @(negedge clk);
      check("midrst_late", {31'd0, busy, hi}, 64'd0);
      check("midrst_late_lo", 64'(lo), 64'd0);

      // 16-bit instance with one-cycle multiply
      a2 = 16'hFFFF; b2 = 16'd1; aluop2 = 3'd0;
      #1 check("w16_add", 64'(c2), 64'd0);
      a2 = 16'h8000; b2 = 16'd4; aluop2 = 3'd5;
      #1 check("w16_sra", 64'(c2), 64'hF800);
      a2 = 16'h8000; b2 = 16'd1; aluop2 = 3'd7;
      #1 check("w16_slt", 64'(c2), 64'd1);
      @(negedge clk);
      start_md2(3'd1, 16'hFFFD, 16'd5);
      wait_done2("w16_mult", 1, 16'hFFFF, 16'hFFF1);
      start_md2(3'd4, 16'd100, 16'd7);
      wait_done2("w16_divu", 3, 16'd2, 16'd14);
      start_md2(3'd3, 16'hFFF9, 16'd2);
      wait_done2("w16_div", 3, 16'hFFFF, 16'hFFFD);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
